// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: address map, c_bus bit indices and d_bus_1 field positions
package bus_responder_pkg;
  localparam logic [31:0] IO_BASE = 32'h0000_0400;
  localparam logic [31:0] ADDR_IN_DATA = 32'h0000_0404;
  localparam logic [31:0] ADDR_OUT_DATA = 32'h0000_0408;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_040C;
  localparam logic [31:0] ADDR_TIMER = 32'h0000_0410;
  localparam int C_RD = 0;
  localparam int C_WR = 1;
  localparam int RD_RDY = 32;
  localparam int WR_RDY = 33;
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction
endpackage

// File: rtl/bus_responder_data_ram.sv
// data_ram: single-port word RAM, async read, sync write, contents not reset
module data_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);
  logic [31:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/bus_responder.sv
// bus_responder: CPU bus target serving data RAM, in/out mailboxes, status and timer
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] IO_BASE   = bus_responder_pkg::IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_bus,
  input  logic [31:0] d_bus_2,
  input  logic [1:0]  c_bus,
  output logic [33:0] d_bus_1,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  logic rd, wr, is_ram, is_in, is_out, is_st, is_tm;
  logic in_full, out_full;
  logic [31:0] in_reg, out_reg, timer, ram_q, rdata;
  assign rd = c_bus[C_RD];
  assign wr = c_bus[C_WR];
  assign is_ram = a_bus < IO_BASE;
  assign is_in = word_match(a_bus, ADDR_IN_DATA);
  assign is_out = word_match(a_bus, ADDR_OUT_DATA);
  assign is_st = word_match(a_bus, ADDR_STATUS);
  assign is_tm = word_match(a_bus, ADDR_TIMER);
  data_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk(clk),
    .we(wr & is_ram),
    .addr(a_bus[ADDR_BITS+1:2]),
    .wdata(d_bus_2),
    .rdata(ram_q)
  );
  // Reserved 0x400 and unmapped addresses fall through to zero
  always_comb
    rdata = !rd   ? 32'h0 :
            is_ram ? ram_q :
            is_in  ? in_reg :
            is_st  ? {30'h0, out_full, in_full} :
            is_tm  ? timer : 32'h0;
  assign d_bus_1[31:0] = rdata;
  assign d_bus_1[RD_RDY] = ~(rd & is_in & ~in_full);
  assign d_bus_1[WR_RDY] = ~(wr & is_out & out_full);
  assign in_ready = ~in_full;
  assign out_valid = out_full;
  assign out_data = out_reg;
  // Capture only while empty, so it can never coincide with a consume
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_full <= 1'b0;
      in_reg <= 32'h0;
    end else if (in_valid & ~in_full) begin
      in_full <= 1'b1;
      in_reg <= in_data;
    end else if (rd & is_in & in_full) in_full <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_full <= 1'b0;
      out_reg <= 32'h0;
    end else if (wr & is_out & ~out_full) begin
      out_full <= 1'b1;
      out_reg <= d_bus_2;
    end else if (out_full & out_ready) out_full <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) timer <= 32'h0;
    else timer <= timer + 32'h1;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scoreboard bench for bus_responder
module tb_bus_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] a_bus = '0, d_bus_2 = '0, in_data = '0, out_data;
  logic [1:0] c_bus = '0;
  logic [33:0] d_bus_1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [33:0] sb [$];
  int n_pass = 0, n_chk = 0;

  bus_responder dut (
    .clk(clk), .rst(rst), .a_bus(a_bus), .d_bus_2(d_bus_2), .c_bus(c_bus),
    .d_bus_1(d_bus_1), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected bus response is queued as the request is driven, then matched against d_bus_1
  task automatic sample(input string tag, input logic [33:0] exp);
    logic [33:0] e;
    sb.push_back(exp);
    #1;
    if (sb.size() == 0) check({tag, "_sb_empty"}, d_bus_1, ~d_bus_1);
    else begin
      e = sb.pop_front();
      check(tag, d_bus_1, e);
    end
  endtask

  task automatic acc(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] c, input logic [33:0] exp);
    a_bus = a;
    d_bus_2 = d;
    c_bus = c;
    sample(tag, exp);
    @(negedge clk);
  endtask

  initial begin
    #2;
    check("rst_in_ready", 34'(in_ready), 34'd1);
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_out_data", 34'(out_data), 34'd0);
    sample("rst_bus", {2'b11, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    acc("timer10", 32'h410, 0, 2'b01, {2'b11, 32'd10});
    acc("ram_wr", 32'h004, 32'hDEADBEEF, 2'b10, {2'b11, 32'h0});
    acc("ram_rd", 32'h004, 0, 2'b01, {2'b11, 32'hDEADBEEF});
    acc("ram_top_wr", 32'h3FC, 32'h0000_1111, 2'b10, {2'b11, 32'h0});
    acc("ram_top_rd", 32'h3FF, 0, 2'b01, {2'b11, 32'h0000_1111});
    acc("ram_rd_again", 32'h004, 0, 2'b01, {2'b11, 32'hDEADBEEF});
    for (int i = 0; i < 3; i++) acc("in_stall", 32'h404, 0, 2'b01, {2'b10, 32'h0});
    in_valid = 1'b1;
    in_data = 32'h12345678;
    check("in_ready_empty", 34'(in_ready), 34'd1);
    acc("in_stall_cap", 32'h404, 0, 2'b01, {2'b10, 32'h0});
    in_valid = 1'b0;
    check("in_ready_full", 34'(in_ready), 34'd0);
    acc("in_rd", 32'h404, 0, 2'b01, {2'b11, 32'h12345678});
    check("in_ready_drained", 34'(in_ready), 34'd1);
    acc("status_empty", 32'h40C, 0, 2'b01, {2'b11, 32'h0});
    acc("out_wr1", 32'h408, 32'hA5, 2'b10, {2'b11, 32'h0});
    check("out_valid1", 34'(out_valid), 34'd1);
    check("out_data1", 34'(out_data), 34'hA5);
    acc("out_wr_stall", 32'h408, 32'h5A, 2'b10, {2'b01, 32'h0});
    check("out_data_hold", 34'(out_data), 34'hA5);
    out_ready = 1'b1;
    acc("out_wr_drain", 32'h408, 32'h5A, 2'b10, {2'b01, 32'h0});
    out_ready = 1'b0;
    acc("out_wr2", 32'h408, 32'h5A, 2'b10, {2'b11, 32'h0});
    check("out_data2", 34'(out_data), 34'h5A);
    check("out_valid2", 34'(out_valid), 34'd1);
    in_valid = 1'b1;
    in_data = 32'hCAFE0001;
    acc("idle", 32'h0, 0, 2'b00, {2'b11, 32'h0});
    in_valid = 1'b0;
    acc("status_full", 32'h40C, 0, 2'b01, {2'b11, 32'h3});
    acc("unmapped_rd", 32'h800, 0, 2'b01, {2'b11, 32'h0});
    acc("reserved_rd", 32'h400, 0, 2'b01, {2'b11, 32'h0});
    acc("reserved_wr", 32'h400, 32'hFFFF_FFFF, 2'b10, {2'b11, 32'h0});
    acc("status_wr", 32'h40C, 32'hFFFF_FFFF, 2'b10, {2'b11, 32'h0});
    acc("status_after", 32'h40D, 0, 2'b01, {2'b11, 32'h3});
    check("out_data_kept", 34'(out_data), 34'h5A);
    acc("illegal_c11", 32'h004, 32'h77, 2'b11, {2'b11, 32'hDEADBEEF});
    acc("illegal_wrote", 32'h004, 0, 2'b01, {2'b11, 32'h77});
    acc("in_rd2", 32'h404, 0, 2'b01, {2'b11, 32'hCAFE0001});
    a_bus = 32'h404;
    c_bus = 2'b01;
    sample("pre_rst_stall", {2'b10, 32'hCAFE0001});
    #1;
    rst = 1'b1;
    c_bus = 2'b00;
    #1;
    check("arst_out_valid", 34'(out_valid), 34'd0);
    check("arst_in_ready", 34'(in_ready), 34'd1);
    sample("arst_bus", {2'b11, 32'h0});
    a_bus = 32'h410;
    c_bus = 2'b01;
    sample("arst_timer", {2'b11, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side end of the CPU's single-cycle memory/I/O bus.
- Decodes the CPU address, serves loads and stores to an internal 256x32 data RAM, and exposes memory-mapped I/O: an input mailbox, an output mailbox, a status word and a free-running timer.
- Drives per-access ready bits. The CPU holds its PC and suppresses its register write while an I/O access is not ready, so a stalled access simply repeats each cycle until it completes.

Parameters:
- ADDR_BITS, 8, log2 of RAM depth in words (256 words, byte addresses 0x000–0x3FF)
- IO_BASE, 32'h0000_0400, first address not backed by RAM

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_bus  in  32  byte address from CPU (ALU result)
- d_bus_2  in  32  store data from CPU
- c_bus  in  2  {mem_write, mem_read}
- d_bus_1  out  34  {wr_rdy, rd_rdy, rdata[31:0]}
- in_data  in  32  data from external producer
- in_valid  in  1  producer has data
- in_ready  out  1  mailbox can accept
- out_data  out  32  data to external consumer
- out_valid  out  1  output mailbox holds data
- out_ready  in  1  consumer accepts

Behaviour:
- Address map (word-matched, a_bus[1:0] ignored):
  - 0x000–0x3FF: RAM, indexed by a_bus[9:2]
  - 0x400: reserved
  - 0x404: IN_DATA (read)
  - 0x408: OUT_DATA (write)
  - 0x40C: STATUS (read)
  - 0x410: TIMER (read)
  - anything else: unmapped
- Reads are combinational. rdata is valid in the same cycle as the request; the CPU captures it at the next posedge.
- RAM: async read; sync write at posedge when mem_write and address < IO_BASE. RAM contents are not reset.
- Input mailbox, state in_full (reset 0):
  - in_ready = ~in_full.
  - On posedge with in_valid & in_ready: in_reg <= in_data, in_full <= 1.
  - Read of IN_DATA: rdata = in_reg, rd_rdy = in_full.
  - On posedge with mem_read & IN_DATA & in_full: in_full <= 0 (consumed).
  - Capture and consume never coincide, because in_ready is low while full.
- Output mailbox, state out_full (reset 0), out_reg (reset 0):
  - out_valid = out_full; out_data = out_reg.
  - Write to OUT_DATA: wr_rdy = ~out_full. On posedge with mem_write & OUT_DATA & ~out_full: out_reg <= d_bus_2, out_full <= 1.
  - On posedge with out_valid & out_ready: out_full <= 0.
  - A write while full is not accepted and is retried by the CPU. Drain and accept never coincide.
- STATUS read: rdata = {30'b0, out_full, in_full}.
- TIMER: 32-bit counter, reset 0, +1 every clock, wraps 0xFFFF_FFFF -> 0. Read returns the pre-increment value.
- Unmapped reads and 0x400 return 0; unmapped writes are ignored. Both assert ready.
- rd_rdy is 0 only for (mem_read & IN_DATA & ~in_full); otherwise 1. wr_rdy is 0 only for (mem_write & OUT_DATA & out_full); otherwise 1. Both are 1 when idle.
- rdata is 0 when mem_read = 0.
- c_bus = 2'b11 is illegal from the CPU: treat it as a write, with rdata still decoded.
- Reset mid-stall: mailboxes empty, timer 0, ready bits follow the rules above immediately. Pending stalled accesses are dropped.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, d_bus_1 = {1,1,32'b0} with no request.

Decomposition:
- Shared package holds:
  - address constants IO_BASE, ADDR_IN_DATA, ADDR_OUT_DATA, ADDR_STATUS, ADDR_TIMER
  - c_bus bit indices
  - d_bus_1 field positions (RD_RDY = 32, WR_RDY = 33)
- Sub-module: data_ram (2^ADDR_BITS x 32, async read, sync write, single port).
- Decode, mailboxes and timer stay in bus_responder.

Test Plan:
- RAM: write 0xDEADBEEF to 0x004, then read 0x004 -> rdata = 0xDEADBEEF, rd_rdy = 1, wr_rdy = 1 throughout.
- Input stall: read 0x404 with mailbox empty for 3 cycles -> rd_rdy = 0 each cycle. Pulse in_valid with 0x12345678 -> next cycle rd_rdy = 1, rdata = 0x12345678. After that posedge in_full = 0 and in_ready = 1.
- Output back-pressure:
  - Write 0xA5 to 0x408 -> out_valid = 1, out_data = 0xA5.
  - Second write 0x5A with out_ready = 0 -> wr_rdy = 0 and out_data stays 0xA5.
  - Raise out_ready for 1 cycle -> next cycle wr_rdy = 1 and 0x5A is accepted.
- STATUS/TIMER: after 10 cycles from reset release, read 0x410 -> 10. With in_full = 1 and out_full = 1, read 0x40C -> 0x3.
- Unmapped/reserved: read 0x800 -> rdata 0, rd_rdy 1. Write 0x400 -> no state change, wr_rdy 1.
- Async reset while output mailbox is full and an input read is stalled -> out_valid 0, in_ready 1, rd_rdy 1 and timer 0 immediately, without waiting for a clock edge.
